// File: rtl/neck_power_ctrl.sv
// Power-switch sequencer for neck events: cut on neck start, restore on
// neck end with minimum/maximum off-time, post-restore blanking and stats.
module neck_power_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MIN_OFF_CYC = 50,
    parameter int MAX_OFF_CYC = 2000,
    parameter int BLANK_CYC   = 500
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_judge,
    input  logic             sample_valid,
    input  logic             neck_start,
    input  logic             neck_end,
    input  logic             clr_flag,
    output logic             power_switch,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cut_cnt,
    output logic [CNT_W-1:0] off_len,
    output logic             timeout_flag
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        CUT   = 2'd2,
        BLANK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_OFF_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LEN    = CNT_W'(MAX_OFF_CYC);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    state_t           st_q, st_d;
    logic [CNT_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_d, off_d;
    logic             pend_q, pend_d;
    logic             pwr_d, to_d;
    logic             start_q, end_q;

    // A simultaneous start/end is spurious: the start is dropped.
    assign start_q = sample_valid & neck_start & ~neck_end;
    assign end_q   = sample_valid & neck_end;

    always_comb begin
        st_d   = st_q;
        tmr_d  = tmr_q;
        pend_d = pend_q;
        pwr_d  = 1'b1;
        off_d  = off_len;
        to_d   = clr_flag ? 1'b0 : timeout_flag;
        cnt_d  = clr_flag ? '0 : cut_cnt;
        unique case (st_q)
            IDLE: begin
                tmr_d  = '0;
                pend_d = 1'b0;
                if (en_judge) st_d = ARMED;
            end
            ARMED: begin
                if (!en_judge) begin
                    st_d = IDLE;
                end else if (start_q) begin
                    st_d   = CUT;
                    tmr_d  = '0;
                    pend_d = 1'b0;
                    pwr_d  = 1'b0;
                    if (cnt_d != CNT_SAT) cnt_d = cnt_d + ONE;
                end
            end
            CUT: begin
                pwr_d = 1'b0;
                tmr_d = tmr_q + ONE;
                if (!en_judge) begin
                    st_d  = IDLE;
                    pwr_d = 1'b1;
                    off_d = tmr_q + ONE;
                    tmr_d = '0;
                end else if ((end_q || pend_q) && tmr_q >= MIN_LAST) begin
                    st_d  = BLANK;
                    pwr_d = 1'b1;
                    off_d = tmr_q + ONE;
                    tmr_d = '0;
                end else begin
                    if (end_q) pend_d = 1'b1;
                    if (tmr_q == MAX_LAST) begin
                        st_d  = BLANK;
                        pwr_d = 1'b1;
                        off_d = MAX_LEN;
                        to_d  = 1'b1;
                        tmr_d = '0;
                    end
                end
            end
            BLANK: begin
                tmr_d = tmr_q + ONE;
                if (!en_judge) begin
                    st_d  = IDLE;
                    tmr_d = '0;
                end else if (tmr_q == BLANK_LAST) begin
                    st_d  = ARMED;
                    tmr_d = '0;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q         <= IDLE;
            tmr_q        <= '0;
            pend_q       <= 1'b0;
            power_switch <= 1'b1;
            cut_cnt      <= '0;
            off_len      <= '0;
            timeout_flag <= 1'b0;
        end else begin
            st_q         <= st_d;
            tmr_q        <= tmr_d;
            pend_q       <= pend_d;
            power_switch <= pwr_d;
            cut_cnt      <= cnt_d;
            off_len      <= off_d;
            timeout_flag <= to_d;
        end
    end

    assign state = st_q;

endmodule

// File: tb/tb_neck_power_ctrl.sv
// Directed bench for neck_power_ctrl: default instance plus a narrow
// instance used to reach counter saturation quickly.
module tb_neck_power_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, sv, st, nd, clr;
    logic        pwr, to;
    logic [1:0]  state;
    logic [15:0] cut_cnt, off_len;

    logic        en2, sv2, st2, nd2, clr2;
    logic        pwr2, to2;
    logic [1:0]  state2;
    logic [3:0]  cut_cnt2, off_len2;

    int checks = 0;
    int failures = 0;
    int offc = 0;
    int k;

    always #5 clk = ~clk;

    neck_power_ctrl dut (
        .clk(clk), .rst_n(rst_n), .en_judge(en), .sample_valid(sv),
        .neck_start(st), .neck_end(nd), .clr_flag(clr),
        .power_switch(pwr), .state(state), .cut_cnt(cut_cnt),
        .off_len(off_len), .timeout_flag(to)
    );

    neck_power_ctrl #(
        .CNT_W(4), .MIN_OFF_CYC(2), .MAX_OFF_CYC(6), .BLANK_CYC(1)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .en_judge(en2), .sample_valid(sv2),
        .neck_start(st2), .neck_end(nd2), .clr_flag(clr2),
        .power_switch(pwr2), .state(state2), .cut_cnt(cut_cnt2),
        .off_len(off_len2), .timeout_flag(to2)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (!pwr) offc++;
        end
    endtask

    task automatic wait_pwr_on(input int bound);
        k = 0;
        while (!pwr && k < bound) begin
            tick();
            k++;
        end
        check("pwr_on_bound", {31'd0, pwr}, 32'd1);
    endtask

    task automatic wait_armed(input int bound);
        k = 0;
        while (state != 2'd1 && k < bound) begin
            tick();
            k++;
        end
        check("armed_bound", {30'd0, state}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        {en, sv, st, nd, clr} = '0;
        {en2, sv2, st2, nd2, clr2} = '0;
        #12;
        check("rst_pwr", {31'd0, pwr}, 32'd1);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_cnt", {16'd0, cut_cnt}, 32'd0);
        check("rst_off", {16'd0, off_len}, 32'd0);
        check("rst_to", {31'd0, to}, 32'd0);
        tick();
        rst_n = 1'b1;
        en = 1'b1;
        tick();
        check("t1_armed", {30'd0, state}, 32'd1);

        // Test 1: normal cut, end at timer 89
        offc = 0;
        sv = 1'b1; st = 1'b1;
        tick();
        st = 1'b0; sv = 1'b0;
        check("t1_cut", {30'd0, state}, 32'd2);
        check("t1_pwr0", {31'd0, pwr}, 32'd0);
        tick(89);
        check("t1_still_off", {31'd0, pwr}, 32'd0);
        sv = 1'b1; nd = 1'b1;
        tick();
        sv = 1'b0; nd = 1'b0;
        check("t1_pwr1", {31'd0, pwr}, 32'd1);
        check("t1_offc", offc, 32'd90);
        check("t1_off_len", {16'd0, off_len}, 32'd90);
        check("t1_blank", {30'd0, state}, 32'd3);
        tick(499);
        check("t1_blank_end", {30'd0, state}, 32'd3);
        tick();
        check("t1_rearmed", {30'd0, state}, 32'd1);
        check("t1_cnt", {16'd0, cut_cnt}, 32'd1);

        // Test 2: early end held pending until min off-time
        offc = 0;
        sv = 1'b1; st = 1'b1;
        tick();
        sv = 1'b0; st = 1'b0;
        tick(5);
        sv = 1'b1; nd = 1'b1;
        tick();
        sv = 1'b0; nd = 1'b0;
        check("t2_pend_off", {31'd0, pwr}, 32'd0);
        wait_pwr_on(200);
        check("t2_offc", offc, 32'd50);
        check("t2_off_len", {16'd0, off_len}, 32'd50);
        check("t2_to", {31'd0, to}, 32'd0);
        check("t2_blank", {30'd0, state}, 32'd3);
        wait_armed(600);

        // Test 3: timeout, then clear
        offc = 0;
        sv = 1'b1; st = 1'b1;
        tick();
        sv = 1'b0; st = 1'b0;
        wait_pwr_on(2100);
        check("t3_offc", offc, 32'd2000);
        check("t3_off_len", {16'd0, off_len}, 32'd2000);
        check("t3_to", {31'd0, to}, 32'd1);
        check("t3_cnt", {16'd0, cut_cnt}, 32'd3);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3_to_clr", {31'd0, to}, 32'd0);
        check("t3_cnt_clr", {16'd0, cut_cnt}, 32'd0);
        wait_armed(600);

        // Test 4: spurious and unqualified starts
        sv = 1'b1; st = 1'b1; nd = 1'b1;
        tick();
        check("t4_both_state", {30'd0, state}, 32'd1);
        check("t4_both_cnt", {16'd0, cut_cnt}, 32'd0);
        check("t4_both_pwr", {31'd0, pwr}, 32'd1);
        sv = 1'b0; nd = 1'b0;
        tick();
        check("t4_nosv_state", {30'd0, state}, 32'd1);
        st = 1'b0;

        // Test 5: start in CUT ignored, en drop at timer 30
        sv = 1'b1; st = 1'b1;
        tick();
        tick(30);
        check("t5_cut_hold", {30'd0, state}, 32'd2);
        check("t5_cnt1", {16'd0, cut_cnt}, 32'd1);
        sv = 1'b0; st = 1'b0;
        en = 1'b0;
        tick();
        check("t5_idle", {30'd0, state}, 32'd0);
        check("t5_pwr", {31'd0, pwr}, 32'd1);
        check("t5_off_len", {16'd0, off_len}, 32'd31);
        en = 1'b1;
        tick();
        sv = 1'b1; st = 1'b1;
        tick();
        sv = 1'b0; st = 1'b0;
        tick(60);
        sv = 1'b1; nd = 1'b1;
        tick();
        nd = 1'b0; st = 1'b1;
        tick(10);
        sv = 1'b0; st = 1'b0;
        check("t5_blank_hold", {30'd0, state}, 32'd3);
        check("t5_blank_pwr", {31'd0, pwr}, 32'd1);
        check("t5_cnt2", {16'd0, cut_cnt}, 32'd2);
        check("t5_off_len2", {16'd0, off_len}, 32'd61);
        wait_armed(600);

        // Test 6: async reset mid-CUT
        sv = 1'b1; st = 1'b1;
        tick();
        sv = 1'b0; st = 1'b0;
        tick(10);
        check("t6_cut_pwr", {31'd0, pwr}, 32'd0);
        rst_n = 1'b0;
        #2;
        check("t6_async_pwr", {31'd0, pwr}, 32'd1);
        check("t6_state", {30'd0, state}, 32'd0);
        check("t6_cnt", {16'd0, cut_cnt}, 32'd0);
        check("t6_off_len", {16'd0, off_len}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Saturation on the narrow instance
        en2 = 1'b1;
        tick();
        for (int i = 0; i < 17; i++) begin
            sv2 = 1'b1; st2 = 1'b1;
            tick();
            sv2 = 1'b0; st2 = 1'b0;
            tick();
            sv2 = 1'b1; nd2 = 1'b1;
            tick();
            sv2 = 1'b0; nd2 = 1'b0;
            tick();
            if (i == 14) check("sat_cnt15", {28'd0, cut_cnt2}, 32'd15);
        end
        check("sat_hold", {28'd0, cut_cnt2}, 32'd15);
        check("sat_state", {30'd0, state2}, 32'd1);
        check("sat_off_len", {28'd0, off_len2}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
